wb_banked_ram_dp: RTL and testbench

//  Dual-port pipelined Wishbone B4 RAM over NUM_BANKS single-port DFFRAM256x32 macros (1 KiB each).

---
 rtl/wb_ram_pkg.sv | 33 +++
 rtl/DFFRAM256x32.sv | 28 ++
 rtl/wb_bank_arb2.sv | 32 +++
 rtl/wb_banked_ram_dp.sv | 151 +++++++++++++++
 tb/tb_wb_banked_ram_dp.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the banked dual-port Wishbone RAM.
package wb_ram_pkg;

  localparam int BANK_WORDS = 256;
  localparam int WORD_BYTES = 4;
  localparam int LAT        = 2;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [WORD_BYTES-1:0] sel;
    logic [7:0]            word;
    logic                  err;
  } ram_req_t;

  function automatic ram_req_t decode_req(
    input logic                  cyc,
    input logic                  stb,
    input logic                  we,
    input logic [WORD_BYTES-1:0] sel,
    input logic [7:0]            word,
    input logic                  err
  );
    ram_req_t r;
    r.valid = cyc & stb;
    r.we    = we;
    r.sel   = sel;
    r.word  = word;
    r.err   = err;
    return r;
  endfunction

endpackage

// File: rtl/DFFRAM256x32.sv
// Behavioural stand-in for the 256x32 single-port DFFRAM macro: byte write
// enables, registered read data that updates only on read accesses.
module DFFRAM256x32
  import wb_ram_pkg::*;
(
  input  logic                  CLK,
  input  logic [WORD_BYTES-1:0] WE0,
  input  logic                  EN0,
  input  logic [7:0]            A0,
  input  logic [31:0]           Di0,
  output logic [31:0]           Do0
);

  logic [31:0] mem [BANK_WORDS];

  // NOTE: the array has no reset; clearing a RAM would turn it into flops and
  // nothing depends on its power-up contents. Non-blocking <= keeps a read in
  // the same edge returning the pre-write word, as the hard macro does.
  always_ff @(posedge CLK) begin
    if (EN0) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (WE0[b]) mem[A0][8*b +: 8] <= Di0[8*b +: 8];
      end
      if (WE0 == '0) Do0 <= mem[A0];
    end
  end

endmodule

// File: rtl/wb_bank_arb2.sv
// Two-requester round-robin arbiter for one bank; the priority bit flips
// only on cycles where both ports want this bank.
module wb_bank_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b
);

  logic pri_q;  // 0: A wins the next conflict

  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      grant_a = ~pri_q;
      grant_b = pri_q;
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              pri_q <= 1'b0;
    else if (req_a && req_b) pri_q <= ~pri_q;
  end

endmodule

// File: rtl/wb_banked_ram_dp.sv
// Dual-port pipelined Wishbone RAM over NUM_BANKS DFFRAM256x32 banks, fixed
// 2-cycle latency. Optional WB_RAM_ERR_EN: out-of-range addresses get err_o.
module wb_banked_ram_dp
  import wb_ram_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pA_cyc_i,
  input  logic                  pA_stb_i,
  input  logic                  pA_we_i,
  input  logic [WORD_BYTES-1:0] pA_sel_i,
  input  logic [ADDR_W-1:0]     pA_adr_i,
  input  logic [31:0]           pA_dat_i,
  output logic                  pA_stall_o,
  output logic                  pA_ack_o,
  output logic                  pA_err_o,
  output logic [31:0]           pA_dat_o,
  input  logic                  pB_cyc_i,
  input  logic                  pB_stb_i,
  input  logic                  pB_we_i,
  input  logic [WORD_BYTES-1:0] pB_sel_i,
  input  logic [ADDR_W-1:0]     pB_adr_i,
  input  logic [31:0]           pB_dat_i,
  output logic                  pB_stall_o,
  output logic                  pB_ack_o,
  output logic                  pB_err_o,
  output logic [31:0]           pB_dat_o
);

  localparam int BB     = $clog2(NUM_BANKS);
  localparam int HI_LSB = 10 + BB;

  typedef logic [BB-1:0] bank_t;
  typedef struct packed {
    logic  valid;
    logic  we;
    logic  err;
    bank_t bank;
  } tag_t;

  logic     hi_a, hi_b;
  ram_req_t req   [2];
  bank_t    bank  [2];
  logic     stall [2];
  logic     acc   [2];
  logic     ack_q [2];
  logic     err_q [2];
  logic [31:0] dat_q [2];
  logic [31:0] bank_do [NUM_BANKS];
  logic [NUM_BANKS-1:0] gnt_a, gnt_b;
  logic unused_adr;

`ifdef WB_RAM_ERR_EN
  assign hi_a = (pA_adr_i >> HI_LSB) != '0;
  assign hi_b = (pB_adr_i >> HI_LSB) != '0;
`else
  assign hi_a = 1'b0;
  assign hi_b = 1'b0;
`endif
  assign unused_adr = ^{pA_adr_i, pB_adr_i};

  assign req[0]  = decode_req(pA_cyc_i, pA_stb_i, pA_we_i, pA_sel_i, pA_adr_i[9:2], hi_a);
  assign req[1]  = decode_req(pB_cyc_i, pB_stb_i, pB_we_i, pB_sel_i, pB_adr_i[9:2], hi_b);
  assign bank[0] = pA_adr_i[HI_LSB-1:10];
  assign bank[1] = pB_adr_i[HI_LSB-1:10];

  // Error requests never reach the arbiters, so they are never stalled.
  assign stall[0] = req[0].valid & ~req[0].err & ~gnt_a[bank[0]];
  assign stall[1] = req[1].valid & ~req[1].err & ~gnt_b[bank[1]];
  assign acc[0]   = req[0].valid & ~stall[0];
  assign acc[1]   = req[1].valid & ~stall[1];

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic                  en;
    logic [WORD_BYTES-1:0] we;
    logic [7:0]            a;
    logic [31:0]           di;

    wb_bank_arb2 u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_a   (req[0].valid & ~req[0].err & (bank[0] == bank_t'(k))),
      .req_b   (req[1].valid & ~req[1].err & (bank[1] == bank_t'(k))),
      .grant_a (gnt_a[k]),
      .grant_b (gnt_b[k])
    );

    always_comb begin
      en = 1'b0;
      we = '0;
      a  = '0;
      di = '0;
      if (gnt_a[k]) begin
        en = 1'b1;
        we = req[0].we ? req[0].sel : '0;
        a  = req[0].word;
        di = pA_dat_i;
      end else if (gnt_b[k]) begin
        en = 1'b1;
        we = req[1].we ? req[1].sel : '0;
        a  = req[1].word;
        di = pB_dat_i;
      end
    end

    DFFRAM256x32 u_ram (
      .CLK (clk_i),
      .WE0 (we),
      .EN0 (en),
      .A0  (a),
      .Di0 (di),
      .Do0 (bank_do[k])
    );
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    tag_t tag_q [LAT-1];
    tag_t last;

    assign last = tag_q[LAT-2];

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        for (int i = 0; i < LAT-1; i++) tag_q[i] <= '0;
        ack_q[p] <= 1'b0;
        err_q[p] <= 1'b0;
        dat_q[p] <= '0;
      end else begin
        tag_q[0] <= '{valid: acc[p], we: req[p].we, err: req[p].err, bank: bank[p]};
        for (int i = 1; i < LAT-1; i++) tag_q[i] <= tag_q[i-1];
        ack_q[p] <= last.valid & ~last.err;
        err_q[p] <= last.valid & last.err;
        // Writes and errors leave the previous read data on dat_o.
        if (last.valid && !last.we && !last.err) dat_q[p] <= bank_do[last.bank];
      end
    end
  end

  assign pA_stall_o = stall[0];
  assign pB_stall_o = stall[1];
  assign pA_ack_o   = ack_q[0];
  assign pB_ack_o   = ack_q[1];
  assign pA_err_o   = err_q[0];
  assign pB_err_o   = err_q[1];
  assign pA_dat_o   = dat_q[0];
  assign pB_dat_o   = dat_q[1];

endmodule

// File: tb/tb_wb_banked_ram_dp.sv
// Directed self-checking bench for wb_banked_ram_dp (NUM_BANKS=4, ADDR_W=13);
// build with or without WB_RAM_ERR_EN.
module tb_wb_banked_ram_dp;

  localparam int ADDR_W = 13;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              pa_cyc, pa_stb, pa_we, pb_cyc, pb_stb, pb_we;
  logic [3:0]        pa_sel, pb_sel;
  logic [ADDR_W-1:0] pa_adr, pb_adr;
  logic [31:0]       pa_wdat, pb_wdat, pa_rdat, pb_rdat;
  logic              pa_stall, pa_ack, pa_err, pb_stall, pb_ack, pb_err;

  wb_banked_ram_dp #(.NUM_BANKS(4), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pA_cyc_i(pa_cyc), .pA_stb_i(pa_stb), .pA_we_i(pa_we), .pA_sel_i(pa_sel),
    .pA_adr_i(pa_adr), .pA_dat_i(pa_wdat), .pA_stall_o(pa_stall), .pA_ack_o(pa_ack),
    .pA_err_o(pa_err), .pA_dat_o(pa_rdat),
    .pB_cyc_i(pb_cyc), .pB_stb_i(pb_stb), .pB_we_i(pb_we), .pB_sel_i(pb_sel),
    .pB_adr_i(pb_adr), .pB_dat_i(pb_wdat), .pB_stall_o(pb_stall), .pB_ack_o(pb_ack),
    .pB_err_o(pb_err), .pB_dat_o(pb_rdat)
  );

  int checks = 0;
  int errors = 0;
  int cnt    = 0;

  typedef struct {
    int          cyc;
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } resp_t;

  resp_t qa[$];
  resp_t qb[$];

  always @(posedge clk_i) cnt <= cnt + 1;

  // Log every response with the cycle it appeared in.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (pa_ack || pa_err) qa.push_back('{cnt, pa_ack, pa_err, pa_rdat});
      if (pb_ack || pb_err) qb.push_back('{cnt, pb_ack, pb_err, pb_rdat});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_a(input logic stb, input logic we, input logic [3:0] sel,
                         input logic [ADDR_W-1:0] adr, input logic [31:0] dat);
    pa_cyc = stb; pa_stb = stb; pa_we = we; pa_sel = sel; pa_adr = adr; pa_wdat = dat;
  endtask

  task automatic drive_b(input logic stb, input logic we, input logic [3:0] sel,
                         input logic [ADDR_W-1:0] adr, input logic [31:0] dat);
    pb_cyc = stb; pb_stb = stb; pb_we = we; pb_sel = sel; pb_adr = adr; pb_wdat = dat;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, 4'h0, '0, '0);
    drive_b(1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic flush();
    idle();
    repeat (4) tick();
    qa.delete();
    qb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++; if (pa_ack !== 1'b0 || pb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b%b expected 00", pa_ack, pb_ack); end
    checks++; if (pa_err !== 1'b0 || pb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b expected 00", pa_err, pb_err); end
    checks++; if (pa_rdat !== 32'h0) begin errors++; $display("FAIL reset_dat_a: got %h expected 0", pa_rdat); end
    checks++; if (pb_rdat !== 32'h0) begin errors++; $display("FAIL reset_dat_b: got %h expected 0", pb_rdat); end
    checks++; if (pa_stall !== 1'b0 || pb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b%b expected 00", pa_stall, pb_stall); end
  endtask

  task automatic preload();
    logic [ADDR_W-1:0] adr [14];
    logic [31:0]       dat [14];
    adr[0] = 13'h000; dat[0] = 32'hA0A0_0000;
    adr[1] = 13'h004; dat[1] = 32'hA0A0_0001;
    for (int i = 0; i < 8; i++) begin
      adr[2+i] = 13'h400 + 13'(4*i);
      dat[2+i] = 32'hB100_0000 + 32'(i);
    end
    adr[10] = 13'h800; dat[10] = 32'hC200_0000;
    adr[11] = 13'h804; dat[11] = 32'h1234_5678;
    adr[12] = 13'h808; dat[12] = 32'hC200_0002;
    adr[13] = 13'h80C; dat[13] = 32'hC200_0003;
    for (int i = 0; i < 14; i++) begin
      drive_a(1'b1, 1'b1, 4'hF, adr[i], dat[i]);
      tick();
    end
    flush();
  endtask

  task automatic test_parallel();
    int c0;
    drive_a(1'b1, 1'b0, 4'hF, 13'h000, '0);
    drive_b(1'b1, 1'b0, 4'hF, 13'h400, '0);
    c0 = cnt;
    @(negedge clk_i);
    checks++; if (pa_stall !== 1'b0 || pb_stall !== 1'b0) begin errors++; $display("FAIL par_stall: got %b%b expected 00", pa_stall, pb_stall); end
    tick();
    idle();
    repeat (4) tick();
    checks++;
    if (qa.size() != 1 || qb.size() != 1) begin
      errors++; $display("FAIL par_count: got %0d/%0d expected 1/1", qa.size(), qb.size());
    end else begin
      checks++; if (qa[0].cyc != c0 + 2 || qb[0].cyc != c0 + 2) begin errors++; $display("FAIL par_latency: got %0d/%0d expected %0d", qa[0].cyc, qb[0].cyc, c0 + 2); end
      checks++; if (qa[0].dat !== 32'hA0A0_0000) begin errors++; $display("FAIL par_dat_a: got %h expected a0a00000", qa[0].dat); end
      checks++; if (qb[0].dat !== 32'hB100_0000) begin errors++; $display("FAIL par_dat_b: got %h expected b1000000", qb[0].dat); end
    end
    flush();
  endtask

  task automatic test_conflict();
    int c0;
    int ia = 0;
    int ib = 0;
    logic [3:0] exp_sa = 4'b1010;
    logic [3:0] exp_sb = 4'b0101;
    c0 = cnt;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b0, 4'hF, 13'h800 + 13'(8*ia), '0);
      drive_b(1'b1, 1'b0, 4'hF, 13'h804 + 13'(8*ib), '0);
      @(negedge clk_i);
      checks++; if (pa_stall !== exp_sa[i] || pb_stall !== exp_sb[i]) begin errors++; $display("FAIL conf_stall_%0d: got %b%b expected %b%b", i, pa_stall, pb_stall, exp_sa[i], exp_sb[i]); end
      if (!exp_sa[i]) ia++;
      if (!exp_sb[i]) ib++;
      tick();
    end
    idle();
    repeat (5) tick();
    checks++;
    if (qa.size() != 2 || qb.size() != 2) begin
      errors++; $display("FAIL conf_count: got %0d/%0d expected 2/2", qa.size(), qb.size());
    end else begin
      checks++; if (qa[0].cyc != c0 + 2 || qa[0].dat !== 32'hC200_0000) begin errors++; $display("FAIL conf_a0: got %0d %h expected %0d c2000000", qa[0].cyc, qa[0].dat, c0 + 2); end
      checks++; if (qb[0].cyc != c0 + 3 || qb[0].dat !== 32'h1234_5678) begin errors++; $display("FAIL conf_b0: got %0d %h expected %0d 12345678", qb[0].cyc, qb[0].dat, c0 + 3); end
      checks++; if (qa[1].cyc != c0 + 4 || qa[1].dat !== 32'hC200_0002) begin errors++; $display("FAIL conf_a1: got %0d %h expected %0d c2000002", qa[1].cyc, qa[1].dat, c0 + 4); end
      checks++; if (qb[1].cyc != c0 + 5 || qb[1].dat !== 32'hC200_0003) begin errors++; $display("FAIL conf_b1: got %0d %h expected %0d c2000003", qb[1].cyc, qb[1].dat, c0 + 5); end
    end
    flush();
  endtask

  task automatic test_byte_write();
    int c0;
    drive_a(1'b1, 1'b1, 4'b0011, 13'h804, 32'hDEAD_BEEF);
    c0 = cnt;
    tick();
    drive_a(1'b1, 1'b0, 4'hF, 13'h804, '0);
    tick();
    idle();
    repeat (4) tick();
    checks++;
    if (qa.size() != 2) begin
      errors++; $display("FAIL bw_count: got %0d expected 2", qa.size());
    end else begin
      checks++; if (qa[0].cyc != c0 + 2 || qa[0].ack !== 1'b1) begin errors++; $display("FAIL bw_wr_ack: got %0d expected %0d", qa[0].cyc, c0 + 2); end
      checks++; if (qa[0].dat !== 32'hC200_0002) begin errors++; $display("FAIL bw_hold: got %h expected c2000002", qa[0].dat); end
      checks++; if (qa[1].cyc != c0 + 3 || qa[1].dat !== 32'h1234_BEEF) begin errors++; $display("FAIL bw_rd: got %0d %h expected %0d 1234beef", qa[1].cyc, qa[1].dat, c0 + 3); end
    end
    flush();
  endtask

  task automatic test_stream();
    int   c0;
    logic stall_seen = 1'b0;
    c0 = cnt;
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 1'b0, 4'hF, 13'h400 + 13'(4*i), '0);
      @(negedge clk_i);
      if (pa_stall !== 1'b0) stall_seen = 1'b1;
      tick();
    end
    idle();
    checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL stream_stall: got 1 expected 0"); end
    repeat (4) tick();
    checks++;
    if (qa.size() != 8) begin
      errors++; $display("FAIL stream_count: got %0d expected 8", qa.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (qa[i].cyc != c0 + 2 + i || qa[i].dat !== 32'hB100_0000 + 32'(i)) begin errors++; $display("FAIL stream_%0d: got %0d %h expected %0d %h", i, qa[i].cyc, qa[i].dat, c0 + 2 + i, 32'hB100_0000 + 32'(i)); end
      end
    end
    flush();
  endtask

  task automatic test_err();
    int c0;
`ifdef WB_RAM_ERR_EN
    drive_a(1'b1, 1'b0, 4'hF, 13'h1000, '0);
    drive_b(1'b1, 1'b0, 4'hF, 13'h0000, '0);
    c0 = cnt;
    @(negedge clk_i);
    checks++; if (pa_stall !== 1'b0 || pb_stall !== 1'b0) begin errors++; $display("FAIL err_stall: got %b%b expected 00", pa_stall, pb_stall); end
    tick();
    drive_b(1'b0, 1'b0, 4'h0, '0, '0);
    drive_a(1'b1, 1'b1, 4'hF, 13'h1004, 32'hFFFF_FFFF);
    tick();
    drive_a(1'b1, 1'b0, 4'hF, 13'h0004, '0);
    tick();
    idle();
    repeat (4) tick();
    checks++;
    if (qa.size() != 3 || qb.size() != 1) begin
      errors++; $display("FAIL err_count: got %0d/%0d expected 3/1", qa.size(), qb.size());
    end else begin
      checks++; if (qa[0].cyc != c0 + 2 || qa[0].err !== 1'b1 || qa[0].ack !== 1'b0) begin errors++; $display("FAIL err_rd: got %0d e%b a%b expected %0d e1 a0", qa[0].cyc, qa[0].err, qa[0].ack, c0 + 2); end
      checks++; if (qa[0].dat !== 32'hB100_0007) begin errors++; $display("FAIL err_hold: got %h expected b1000007", qa[0].dat); end
      checks++; if (qa[1].err !== 1'b1 || qa[1].ack !== 1'b0) begin errors++; $display("FAIL err_wr: got e%b a%b expected e1 a0", qa[1].err, qa[1].ack); end
      checks++; if (qa[2].ack !== 1'b1 || qa[2].dat !== 32'hA0A0_0001) begin errors++; $display("FAIL err_nowrite: got %h expected a0a00001", qa[2].dat); end
      checks++; if (qb[0].ack !== 1'b1 || qb[0].dat !== 32'hA0A0_0000) begin errors++; $display("FAIL err_b: got %h expected a0a00000", qb[0].dat); end
    end
`else
    drive_a(1'b1, 1'b1, 4'hF, 13'h1004, 32'h5A5A_5A5A);
    c0 = cnt;
    tick();
    drive_a(1'b1, 1'b0, 4'hF, 13'h1000, '0);
    tick();
    drive_a(1'b1, 1'b0, 4'hF, 13'h0004, '0);
    tick();
    idle();
    repeat (4) tick();
    checks++;
    if (qa.size() != 3) begin
      errors++; $display("FAIL alias_count: got %0d expected 3", qa.size());
    end else begin
      checks++; if (qa[0].cyc != c0 + 2 || qa[0].ack !== 1'b1 || qa[0].err !== 1'b0) begin errors++; $display("FAIL alias_wr: got %0d a%b e%b expected %0d a1 e0", qa[0].cyc, qa[0].ack, qa[0].err, c0 + 2); end
      checks++; if (qa[1].dat !== 32'hA0A0_0000 || qa[1].err !== 1'b0) begin errors++; $display("FAIL alias_rd0: got %h expected a0a00000", qa[1].dat); end
      checks++; if (qa[2].cyc != c0 + 4 || qa[2].dat !== 32'h5A5A_5A5A) begin errors++; $display("FAIL alias_rd1: got %0d %h expected %0d 5a5a5a5a", qa[2].cyc, qa[2].dat, c0 + 4); end
    end
`endif
    flush();
  endtask

  task automatic test_reset_midflight();
    // One conflict on bank 2 leaves B favoured before the reset.
    drive_a(1'b1, 1'b0, 4'hF, 13'h800, '0);
    drive_b(1'b1, 1'b0, 4'hF, 13'h804, '0);
    @(negedge clk_i);
    checks++; if (pb_stall !== 1'b1 || pa_stall !== 1'b0) begin errors++; $display("FAIL rst_pre: got %b%b expected 01", pa_stall, pb_stall); end
    tick();
    flush();
    drive_a(1'b1, 1'b0, 4'hF, 13'h000, '0);
    drive_b(1'b1, 1'b0, 4'hF, 13'h400, '0);
    tick();
    idle();
    rst_i = 1'b0;
    repeat (2) tick();
    checks++; if (pa_ack !== 1'b0 || pb_ack !== 1'b0 || pa_rdat !== 32'h0) begin errors++; $display("FAIL rst_during: got a%b%b d%h expected 00 0", pa_ack, pb_ack, pa_rdat); end
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) tick();
    checks++; if (qa.size() != 0 || qb.size() != 0) begin errors++; $display("FAIL rst_dropped: got %0d/%0d acks expected 0/0", qa.size(), qb.size()); end
    checks++; if (pb_rdat !== 32'h0) begin errors++; $display("FAIL rst_dat_b: got %h expected 0", pb_rdat); end
    drive_a(1'b1, 1'b0, 4'hF, 13'h800, '0);
    drive_b(1'b1, 1'b0, 4'hF, 13'h804, '0);
    @(negedge clk_i);
    checks++; if (pa_stall !== 1'b0 || pb_stall !== 1'b1) begin errors++; $display("FAIL rst_pri: got %b%b expected 01", pa_stall, pb_stall); end
    tick();
    flush();
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_i = 1'b1;
    tick();
    preload();
    test_parallel();
    test_conflict();
    test_byte_write();
    test_stream();
    test_err();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
